fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that lets N_REQ independent producers share the single write port of one FIFO instance.
- Each producer uses a valid/ready handshake.
- The arbiter drives the FIFO write side (i_Wr_DV/i_Wr_Data) from a registered output stage.
- It throttles producers using the FIFO's Full and almost-full flags.
- A grant is held for up to MAX_BURST consecutive words, so producers' words stay contiguous in the FIFO.

Parameters:
N_REQ, 2, number of requesters (2..8)
WIDTH, 8, data width; equals the FIFO WIDTH
MAX_BURST, 4, maximum consecutive words accepted from one requester before the grant is forced to rotate (1..16)

Ports:
i_Clk  in  1  clock
i_Rst_L  in  1  synchronous reset, active low
i_Req_DV  in  N_REQ  per-requester data valid
i_Req_Data  in  N_REQ*WIDTH  packed requester data; requester n occupies bits [n*WIDTH +: WIDTH]
o_Req_Ready  out  N_REQ  per-requester ready (one-hot or zero); a word transfers when DV and Ready are both 1
o_Grant_Idx  out  $clog2(N_REQ) (min 1)  index of the current grant holder; valid while o_Busy=1
o_Busy  out  1  grant currently held
o_Wr_DV  out  1  to FIFO i_Wr_DV
o_Wr_Data  out  WIDTH  to FIFO i_Wr_Data
i_Full  in  1  from FIFO o_Full
i_AF_Flag  in  1  from FIFO o_AF_Flag; the integrator sets FIFO i_AF_Level = DEPTH-1

Behaviour:
- Reset (i_Rst_L=0 sampled at a rising edge) sets:
  - o_Wr_DV=0, o_Wr_Data=0, o_Req_Ready=0, o_Busy=0, o_Grant_Idx=0
  - RR pointer=0, burst count=0, state=IDLE
- Reset is honoured mid-burst. A word already presented on o_Wr_DV in the reset cycle is not re-issued.
- Space term: Space = !i_Full && (!i_AF_Flag || !o_Wr_DV). This guarantees that an accepted word plus a registered write in flight never overflows the FIFO.
- o_Req_Ready[g] is combinational: (state==GRANT) && (g==o_Grant_Idx) && Space. All other ready bits are 0.
- A transfer occurs when i_Req_DV[g] && o_Req_Ready[g]. On the next edge:
  - o_Wr_DV<=1 and o_Wr_Data<=the granted requester's data (1-cycle latency).
  - Otherwise o_Wr_DV<=0 and o_Wr_Data holds its value.
- FSM states: IDLE, GRANT.
  - IDLE: if any i_Req_DV bit is set, choose the first set bit at or after the RR pointer (wrapping modulo N_REQ). Then go to GRANT with grant=that index, burst count=0, o_Busy=1.
  - IDLE to GRANT costs one cycle; no word transfers in IDLE.
- GRANT rules:
  - Each transfer increments the burst count.
  - Release the grant after the transfer that makes count==MAX_BURST, or in any cycle where i_Req_DV[g]==0 (requester idle, not stalled by Space).
  - On release: RR pointer <= (g+1) mod N_REQ, o_Busy <= 0, state <= IDLE.
  - A requester stalled only by back-pressure (DV=1, Space=0) keeps the grant indefinitely; the burst count does not advance.
- Fairness: with all requesters continuously valid and no back-pressure, grants rotate 0,1,...,N_REQ-1,0 with exactly MAX_BURST words each.
- Producers must hold data stable while DV=1 and Ready=0. The arbiter never drops or duplicates a word.
- Simultaneous events:
  - A new request from a non-granted requester during GRANT has no effect until release.
  - A release and a new IDLE selection never occur in the same cycle.

Decomposition:
- Shared package fifo_pkg holds:
  - the arb_state_t enum (IDLE, GRANT)
  - a clog2-with-minimum-1 constant function
  - the AF-level integration rule DEPTH-1 as a documented localparam helper
- One natural sub-module, rr_pick: a combinational round-robin first-set-bit-from-pointer picker (inputs: request vector, pointer; outputs: found, index). It is reusable by later read-side schedulers.

Test Plan:
1. Reset, then single requester 0 sends 3 words 0x11,0x22,0x33 back-to-back with DV held -> FIFO receives exactly 0x11,0x22,0x33 in order; o_Wr_DV first high 2 cycles after DV rises (IDLE->GRANT, then register); grant releases when DV drops.
2. N_REQ=2, MAX_BURST=4, both requesters continuously valid with incrementing data (req0: 0x00.., req1: 0x80..), FIFO drained every cycle -> write order 00,01,02,03,80,81,82,83,04,...; o_Grant_Idx alternates 0,1,0.
3. FIFO DEPTH=4 with nothing read, req0 streams 6 words -> exactly 4 written; o_Req_Ready[0] low once the FIFO is full; i_Full never seen high together with o_Wr_DV=1. Then read one word -> word 5 accepted; no loss or duplicate.
4. Requester 1 raises DV while requester 0 is mid-burst (count=2) -> req1 Ready stays 0 until req0 finishes its 4th word; req1 is granted next.
5. Assert i_Rst_L=0 for 1 cycle mid-burst after 2 of 4 words -> on the next cycle o_Wr_DV=0, o_Busy=0, o_Req_Ready=0, RR pointer=0; the next grant goes to the lowest-index requester with DV set.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the FIFO write-side arbiter
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // $clog2 that never returns 0, so a 1-entry index still has a bit
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // The arbiter's Space term assumes the FIFO raises almost-full one entry
  // before Full, i.e. the FIFO is built with i_AF_Level = DEPTH - 1.
  localparam int AF_LEVEL_MARGIN = 1;

  function automatic int af_level_for_depth(input int depth);
    return depth - AF_LEVEL_MARGIN;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer handshake and FIFO write-port bundle
interface fifo_wr_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 8
);
  import fifo_pkg::*;

  localparam int IDX_W = clog2_min1(N_REQ);

  logic [N_REQ-1:0]       i_Req_DV;
  logic [N_REQ*WIDTH-1:0] i_Req_Data;
  logic [N_REQ-1:0]       o_Req_Ready;
  logic [IDX_W-1:0]       o_Grant_Idx;
  logic                   o_Busy;
  logic                   o_Wr_DV;
  logic [WIDTH-1:0]       o_Wr_Data;
  logic                   i_Full;
  logic                   i_AF_Flag;

  modport master (
    input  i_Req_DV, i_Req_Data, i_Full, i_AF_Flag,
    output o_Req_Ready, o_Grant_Idx, o_Busy, o_Wr_DV, o_Wr_Data
  );

  modport slave (
    output i_Req_DV, i_Req_Data, i_Full, i_AF_Flag,
    input  o_Req_Ready, o_Grant_Idx, o_Busy, o_Wr_DV, o_Wr_Data
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - first set request bit at or after a pointer, wrapping
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  fifo_wr_arbiter_if.master  bus
);

  localparam int IDX_W = clog2_min1(N_REQ);
  localparam int CNT_W = clog2_min1(MAX_BURST + 1);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [CNT_W-1:0] burst_cnt;
  logic             busy_q;
  logic             wr_dv_q;
  logic [WIDTH-1:0] wr_data_q;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             space;
  logic             dv_g;
  logic             xfer;
  logic             release_grant;
  logic [IDX_W-1:0] next_ptr;
  logic [WIDTH-1:0] sel_data;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (bus.i_Req_DV),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // With AF at DEPTH-1, one accepted word plus one registered write in flight
  // always fits, so only stall on AF when a write is already in flight.
  assign space = !bus.i_Full && (!bus.i_AF_Flag || !wr_dv_q);

  assign dv_g     = bus.i_Req_DV[grant_idx];
  assign sel_data = bus.i_Req_Data[int'(grant_idx)*WIDTH +: WIDTH];
  assign xfer     = (state == GRANT) && dv_g && space;

  // Back-pressure alone never releases; only an idle requester or a full burst does.
  assign release_grant = (state == GRANT) &&
                         (!dv_g || (xfer && burst_cnt == CNT_W'(MAX_BURST - 1)));

  assign next_ptr = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  assign bus.o_Req_Ready = ((state == GRANT) && space) ? (N_REQ'(1) << grant_idx) : '0;
  assign bus.o_Grant_Idx = grant_idx;
  assign bus.o_Busy      = busy_q;
  assign bus.o_Wr_DV     = wr_dv_q;
  assign bus.o_Wr_Data   = wr_data_q;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      burst_cnt <= '0;
      busy_q    <= 1'b0;
      wr_dv_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_dv_q <= xfer;
      if (xfer) begin
        wr_data_q <= sel_data;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= GRANT;
            grant_idx <= pick_idx;
            burst_cnt <= '0;
            busy_q    <= 1'b1;
          end
        end
        GRANT: begin
          if (release_grant) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            burst_cnt <= '0;
            rr_ptr    <= next_ptr;
          end else if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized and directed bench with a behavioural arbiter/FIFO model
module tb_fifo_wr_arbiter;
  import fifo_pkg::*;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .WIDTH     (W),
    .MAX_BURST (MB)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_l),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  // producers: each has a queue of words still to send
  logic [W-1:0] src_q[N][$];
  bit           dv[N];
  int           dv_pct = 100;
  int           rd_pct = 100;
  bit           rd_once = 0;
  bit           rd_now = 0;
  int           fifo_depth = 16;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] wr_log[$];
  int           grant_log[$];
  bit           last_busy = 0;
  bit           seq_chk = 0;
  int           next_seq[N];
  int           cyc = 0;
  int           dv_rise_cyc = -1;
  int           wr_first_cyc = -1;

  // behavioural model: who holds the port, words taken in this burst, where to look next
  bit           m_busy = 0;
  int           m_g = 0;
  int           m_cnt = 0;
  int           m_ptr = 0;
  bit           m_wr_dv = 0;
  logic [W-1:0] m_wr_data = '0;
  logic [N-1:0] exp_rdy = '0;

  bit           p_dv[N];
  logic [W-1:0] p_data[N];
  logic [N-1:0] p_rdy;
  bit           p_full, p_af, p_rst, p_rd, p_wr;
  logic [W-1:0] p_wrd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_advance();
    bit sp, xf;
    if (!p_rst) begin
      m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = 0; m_wr_dv = 0; m_wr_data = '0;
      return;
    end
    sp = !p_full && (!p_af || !m_wr_dv);
    xf = m_busy && p_dv[m_g] && sp;
    m_wr_dv = xf;
    if (xf) m_wr_data = p_data[m_g];
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (!m_busy && p_dv[(m_ptr + k) % N]) begin
          m_busy = 1; m_g = (m_ptr + k) % N; m_cnt = 0;
        end
      end
    end else if (!p_dv[m_g] || (xf && m_cnt + 1 == MB)) begin
      m_busy = 0; m_cnt = 0; m_ptr = (m_g + 1) % N;
    end else if (xf) begin
      m_cnt++;
    end
  endtask

  task automatic compare();
    bit sp;
    sp = !bus.i_Full && (!bus.i_AF_Flag || !m_wr_dv);
    exp_rdy = (m_busy && sp) ? (N'(1) << m_g) : '0;
    check("ready", bus.o_Req_Ready, exp_rdy);
    check("busy", bus.o_Busy, m_busy);
    check("wr_dv", bus.o_Wr_DV, m_wr_dv);
    check("wr_data", bus.o_Wr_Data, m_wr_data);
    if (m_busy) check("grant_idx", bus.o_Grant_Idx, m_g);
    if (bus.o_Busy && !last_busy) grant_log.push_back(int'(bus.o_Grant_Idx));
    last_busy = bus.o_Busy;
    if (dv_rise_cyc < 0 && bus.i_Req_DV[0]) dv_rise_cyc = cyc;
    if (wr_first_cyc < 0 && bus.o_Wr_DV) wr_first_cyc = cyc;
  endtask

  task automatic step();
    for (int n = 0; n < N; n++) begin
      p_dv[n]   = bus.i_Req_DV[n];
      p_data[n] = bus.i_Req_Data[n*W +: W];
    end
    p_rdy  = exp_rdy;
    p_full = bus.i_Full;
    p_af   = bus.i_AF_Flag;
    p_rst  = rst_l;
    p_rd   = rd_now;
    p_wr   = bus.o_Wr_DV;
    p_wrd  = bus.o_Wr_Data;
    @(posedge clk);
    #1;
    cyc++;
    model_advance();
    if (p_wr) begin
      if (p_full) check("wr_while_full", 1, 0);
      fifo_q.push_back(p_wrd);
      wr_log.push_back(p_wrd);
      if (seq_chk) begin
        check("per_req_order", p_wrd[6:0], 7'(next_seq[p_wrd[7]]));
        next_seq[p_wrd[7]]++;
      end
    end
    if (p_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
    for (int n = 0; n < N; n++) begin
      if (p_rst && p_dv[n] && p_rdy[n]) begin
        void'(src_q[n].pop_front());
        dv[n] = 0;
      end
      if (!dv[n] && src_q[n].size() > 0 && $urandom_range(99) < dv_pct) dv[n] = 1;
      bus.i_Req_DV[n] = dv[n];
      bus.i_Req_Data[n*W +: W] = (src_q[n].size() > 0) ? src_q[n][0] : W'($urandom);
    end
    rd_now = ($urandom_range(99) < rd_pct) || rd_once;
    rd_once = 0;
    bus.i_Full    = (fifo_q.size() >= fifo_depth);
    bus.i_AF_Flag = (fifo_q.size() >= af_level_for_depth(fifo_depth));
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst_l = 0;
    step();
    step();
    rst_l = 1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    grant_log.delete();
  endtask

  initial begin
    bus.i_Req_DV = '0;
    bus.i_Req_Data = '0;
    bus.i_Full = 0;
    bus.i_AF_Flag = 0;

    // reset values
    do_reset();
    check("rst_wr_dv", bus.o_Wr_DV, 0);
    check("rst_wr_data", bus.o_Wr_Data, 0);
    check("rst_ready", bus.o_Req_Ready, 0);
    check("rst_busy", bus.o_Busy, 0);
    check("rst_grant", bus.o_Grant_Idx, 0);

    // single requester, three words back-to-back
    clear_logs();
    dv_rise_cyc = -1; wr_first_cyc = -1;
    src_q[0] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 10; i++) step();
    check("t1_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      check("t1_w0", wr_log[0], 8'h11);
      check("t1_w1", wr_log[1], 8'h22);
      check("t1_w2", wr_log[2], 8'h33);
    end
    check("t1_latency", wr_first_cyc - dv_rise_cyc, 2);
    check("t1_released", bus.o_Busy, 0);

    // fairness: both continuously valid, FIFO drained every cycle
    do_reset();
    clear_logs();
    for (int k = 0; k < 16; k++) begin
      src_q[0].push_back(W'(k));
      src_q[1].push_back(W'(8'h80 + k));
    end
    for (int i = 0; i < 60; i++) step();
    check("t2_count", wr_log.size(), 32);
    begin
      logic [W-1:0] exp_order[12];
      exp_order = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h81, 8'h82, 8'h83,
                    8'h04, 8'h05, 8'h06, 8'h07};
      for (int i = 0; i < 12 && i < wr_log.size(); i++) check("t2_order", wr_log[i], exp_order[i]);
    end
    if (grant_log.size() >= 4) begin
      check("t2_g0", grant_log[0], 0);
      check("t2_g1", grant_log[1], 1);
      check("t2_g2", grant_log[2], 0);
      check("t2_g3", grant_log[3], 1);
    end else check("t2_grants", grant_log.size(), 4);

    // depth-4 FIFO, no reads: exactly four accepted, then one after a read
    do_reset();
    clear_logs();
    fifo_q.delete();
    fifo_depth = 4;
    rd_pct = 0;
    src_q[0] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    for (int i = 0; i < 20; i++) step();
    check("t3_written", wr_log.size(), 4);
    check("t3_ready_low", bus.o_Req_Ready[0], 0);
    check("t3_stalled_busy", bus.o_Busy, 1);
    rd_once = 1;
    for (int i = 0; i < 10; i++) step();
    check("t3_after_read", wr_log.size(), 5);
    if (wr_log.size() >= 5) check("t3_w5", wr_log[4], 8'h45);
    src_q[0].delete();
    dv[0] = 0;
    fifo_depth = 16;
    rd_pct = 100;
    for (int i = 0; i < 6; i++) step();

    // req1 arrives mid-burst; req0 keeps its full burst of four
    do_reset();
    clear_logs();
    src_q[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    for (int i = 0; i < 40 && wr_log.size() < 1; i++) step();
    check("t4_reach", wr_log.size() >= 1, 1);
    src_q[1] = '{8'h90};
    for (int i = 0; i < 20; i++) step();
    begin
      logic [W-1:0] exp4[7];
      exp4 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h90, 8'h05, 8'h06};
      check("t4_count", wr_log.size(), 7);
      for (int i = 0; i < 7 && i < wr_log.size(); i++) check("t4_order", wr_log[i], exp4[i]);
    end

    // reset mid-burst
    do_reset();
    clear_logs();
    src_q[0] = '{8'h01, 8'h02, 8'h03, 8'h04};
    src_q[1] = '{8'h81, 8'h82};
    for (int i = 0; i < 40 && wr_log.size() < 2; i++) step();
    check("t5_reach", wr_log.size() >= 2, 1);
    rst_l = 0;
    step();
    rst_l = 1;
    check("t5_wr_dv", bus.o_Wr_DV, 0);
    check("t5_busy", bus.o_Busy, 0);
    check("t5_ready", bus.o_Req_Ready, 0);
    step();
    check("t5_regrant_busy", bus.o_Busy, 1);
    check("t5_regrant_idx", bus.o_Grant_Idx, 0);
    for (int i = 0; i < 30; i++) step();
    check("t5_drained", src_q[0].size() + src_q[1].size(), 0);

    // randomized traffic with back-pressure
    do_reset();
    clear_logs();
    fifo_q.delete();
    fifo_depth = 6;
    rd_pct = 40;
    dv_pct = 60;
    for (int n = 0; n < N; n++) begin
      next_seq[n] = 0;
      for (int k = 0; k < 60; k++) src_q[n].push_back(W'((n << 7) | k));
    end
    seq_chk = 1;
    for (int i = 0; i < 4000 && (src_q[0].size() + src_q[1].size() > 0 || bus.o_Busy); i++) step();
    for (int i = 0; i < 4; i++) step();
    seq_chk = 0;
    check("rand_drained", src_q[0].size() + src_q[1].size(), 0);
    check("rand_total", wr_log.size(), 120);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
